operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Issue/operand-read stage that sits directly upstream of the 32x32 register file and consumes its two combinational read ports.
- Accepts decoded instructions over valid/ready and drives rs1/rs2 read addresses to the RF.
- Bypasses same-cycle writeback data and blocks RAW/WAW hazards with a pending-write scoreboard.
- Registers operands into an output slot for the execute stage.

Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers; x0 is always zero
- AW, 5, register index width (clog2 NREG)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage accepts instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1, in_rs2, in_rd  in  AW  register indices
- in_use_rs1, in_use_rs2  in  1  source operand is read
- in_wr_rd  in  1  instruction writes rd
- rf_raddr1, rf_raddr2  out  AW  RF read addresses (combinational from in_rs1/in_rs2)
- rf_rdata1, rf_rdata2  in  XLEN  RF read data
- wb_en  in  1  writeback this cycle (same signals drive the RF write port)
- wb_addr  in  AW  writeback index
- wb_data  in  XLEN  writeback data
- flush  in  1  discard the output slot
- out_valid  out  1  output slot valid
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  registered PC
- out_rs1_val, out_rs2_val  out  XLEN  registered operands
- out_rd  out  AW  registered rd
- out_wr_rd  out  1  registered write flag
- pending  out  NREG  scoreboard bits (debug/verification)

Behaviour:
- Reset, asynchronous, active while rst=0: out_valid=0; pending=0; out_pc, out_rs1_val, out_rs2_val, out_rd, out_wr_rd=0.
- wb_clr[i] = wb_en && wb_addr==i && i!=0. Effective pending: epend = pending & ~wb_clr.
- hazard = (in_use_rs1 && epend[in_rs1]) || (in_use_rs2 && epend[in_rs2]) || (in_wr_rd && in_rd!=0 && epend[in_rd]).
- slot_free = !out_valid || out_ready.
- in_ready = slot_free && !hazard && !flush. It is combinational and does not depend on in_valid.
- Issue when in_valid && in_ready. Capture into the output slot on the next rising edge; one-cycle latency.
- Operand select per source:
  - index 0 gives 0;
  - otherwise, if wb_en && wb_addr==idx, use wb_data (bypass, because an RF write becomes visible only after the edge);
  - otherwise use rf_rdata.
  - Unused sources are still captured as selected; their values are don't-care to consumers.
- Scoreboard next state = (pending & ~wb_clr) | (issue && in_wr_rd && in_rd!=0 ? onehot(in_rd) : 0). Set wins over clear on the same index in the same cycle. Bit 0 is never set.
- Output slot:
  - issue: load the slot, out_valid=1;
  - else if out_valid && out_ready: out_valid=0;
  - slot contents hold while out_valid && !out_ready.
- flush:
  - out_valid becomes 0 next edge;
  - if the slot held a valid entry with out_wr_rd && out_rd!=0, clear pending[out_rd], since the dropped instruction will never write back;
  - no issue occurs in a flush cycle.
- A writeback to an index with no pending bit is legal; that bit stays 0.
- Reset mid-operation clears all state immediately, independent of clk.

Decomposition:
- Shared package (core_pkg): XLEN, NREG, AW constants; a struct for the decoded-issue bundle (pc, rs1, rs2, rd, use flags, wr_rd).
- Natural sub-module: scoreboard. It holds the pending vector and handles set/clear/flush-clear, and exposes epend.
- Bypass muxes and the output slot stay in the top level.

Test Plan:
- Reset then RF x5=0x1234; issue rs1=5, rs2=0 -> next cycle out_valid=1, out_rs1_val=0x1234, out_rs2_val=0.
- Issue A (rd=3, wr_rd) then B (rs1=3) -> pending[3]=1 and in_ready=0 for B. Apply wb_en, wb_addr=3, wb_data=0xCAFE -> B issues that cycle and out_rs1_val=0xCAFE (bypass).
- WAW: pending[7]=1, instruction with rd=7 -> held; issues in the cycle wb_addr=7 arrives, and pending[7] stays 1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0 and outputs are stable; out_ready=1 with in_valid=1 -> back-to-back issue.
- rd=0 with wr_rd=1 -> pending stays 0; a following instruction with rs1=0 gets 0 with no stall.
- Flush with slot holding rd=9, wr_rd=1 -> out_valid=0 and pending[9]=0. Assert rst=0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and the decoded-issue bundle for the operand-fetch stage.
package core_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic            use_rs1;
        logic            use_rs2;
        logic            wr_rd;
    } issue_t;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per register with an in-flight writer.
module operand_fetch_scoreboard
    import core_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic            i_set_en,
    input  logic [AW-1:0]   i_set_idx,
    input  logic            i_clr_en,
    input  logic [AW-1:0]   i_clr_idx,
    output logic [NREG-1:0] o_pending,
    output logic [NREG-1:0] o_epend
);

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_wb_clr;
    logic [NREG-1:0] w_fl_clr;
    logic [NREG-1:0] w_set;

    // x0 is never tracked, so every update masks out index 0
    assign w_wb_clr = (i_wb_en  && i_wb_addr != '0) ? onehot(i_wb_addr) : '0;
    assign w_fl_clr = (i_clr_en && i_clr_idx != '0) ? onehot(i_clr_idx) : '0;
    assign w_set    = (i_set_en && i_set_idx != '0) ? onehot(i_set_idx) : '0;

    assign o_epend   = r_pending & ~w_wb_clr;
    assign o_pending = r_pending;

    // Set is OR-ed last so it wins over a same-cycle writeback clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pending <= '0;
        else          r_pending <= (r_pending & ~w_wb_clr & ~w_fl_clr) | w_set;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-read stage: hazard-checked issue, writeback bypass, registered output slot.
module operand_fetch
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic            in_wr_rd,
    output logic [AW-1:0]   rf_raddr1,
    output logic [AW-1:0]   rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [AW-1:0]   out_rd,
    output logic            out_wr_rd,
    output logic [NREG-1:0] pending
);

    issue_t          w_ins;
    issue_t          r_slot;
    logic            r_out_valid;
    logic [XLEN-1:0] r_rs1_val;
    logic [XLEN-1:0] r_rs2_val;
    logic [NREG-1:0] w_epend;
    logic            w_hazard;
    logic            w_slot_free;
    logic            w_issue;
    logic            w_fl_clr;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    assign w_ins = '{pc: in_pc, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                     use_rs1: in_use_rs1, use_rs2: in_use_rs2, wr_rd: in_wr_rd};

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    assign w_hazard = (in_use_rs1 && w_epend[in_rs1]) ||
                      (in_use_rs2 && w_epend[in_rs2]) ||
                      (in_wr_rd && in_rd != '0 && w_epend[in_rd]);

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = w_slot_free && !w_hazard && !flush;
    assign w_issue     = in_valid && in_ready;

    // RF writes land after the edge, so a same-cycle writeback must be forwarded
    assign w_op1 = (in_rs1 == '0) ? '0 :
                   (wb_en && wb_addr == in_rs1) ? wb_data : rf_rdata1;
    assign w_op2 = (in_rs2 == '0) ? '0 :
                   (wb_en && wb_addr == in_rs2) ? wb_data : rf_rdata2;

    // A flushed writer will never write back, so release its pending bit
    assign w_fl_clr = flush && r_out_valid && r_slot.wr_rd;

    operand_fetch_scoreboard u_sb (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_set_en  (w_issue && in_wr_rd),
        .i_set_idx (in_rd),
        .i_clr_en  (w_fl_clr),
        .i_clr_idx (r_slot.rd),
        .o_pending (pending),
        .o_epend   (w_epend)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_slot      <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_slot      <= w_ins;
            r_rs1_val   <= w_op1;
            r_rs2_val   <= w_op2;
        end else if (flush || (r_out_valid && out_ready)) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_slot.pc;
    assign out_rs1_val = r_rs1_val;
    assign out_rs2_val = r_rs2_val;
    assign out_rd      = r_slot.rd;
    assign out_wr_rd   = r_slot.wr_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: RF model, output scoreboard queue, hazard vector table, corner sequences.
module tb_operand_fetch;

    logic        clk, rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2, in_wr_rd;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush, out_valid, out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_wr_rd;
    logic [31:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    bit [31:0] rf [32];

    typedef struct {
        logic [31:0] pc, v1, v2;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;
    exp_t q[$];

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, wr;
        logic       wbe;
        logic [4:0] wba;
        logic       fl;
        logic       exp_ready;
    } vec_t;
    vec_t vecs[11];

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_wr_rd(in_wr_rd),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_wr_rd(out_wr_rd), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write visible after the edge
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    always @(posedge clk) if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sel(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return rf[idx];
    endfunction

    // Pop/compare completed outputs first, then push the instruction issuing at the coming edge
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && (out_ready || flush)) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (!flush) begin
                        chk("sb_pc",  out_pc,      e.pc);
                        chk("sb_rs1", out_rs1_val, e.v1);
                        chk("sb_rs2", out_rs2_val, e.v2);
                        chk("sb_rd",  {27'd0, out_rd},    {27'd0, e.rd});
                        chk("sb_wr",  {31'd0, out_wr_rd}, {31'd0, e.wr});
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back('{pc: in_pc, v1: sel(in_rs1), v2: sel(in_rs2), rd: in_rd, wr: in_wr_rd});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic u1, input logic u2, input logic wr);
        in_valid = 1'b1; in_pc = pc; in_rs1 = r1; in_rs2 = r2; in_rd = rd;
        in_use_rs1 = u1; in_use_rs2 = u2; in_wr_rd = wr;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    initial begin
        //              name            rs1   rs2   rd   u1 u2 wr wbe wba  fl rdy
        vecs[0]  = '{"raw_rs1",       5'd3, 5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0};
        vecs[1]  = '{"unused_rs1",    5'd3, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1};
        vecs[2]  = '{"raw_rs2",       5'd0, 5'd7, 5'd0, 0, 1, 0, 0, 5'd0, 0, 0};
        vecs[3]  = '{"waw_rd",        5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 5'd0, 0, 0};
        vecs[4]  = '{"rd_no_write",   5'd0, 5'd0, 5'd7, 0, 0, 0, 0, 5'd0, 0, 1};
        vecs[5]  = '{"x0_only",       5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 0, 1};
        vecs[6]  = '{"wb_clears",     5'd3, 5'd0, 5'd0, 1, 0, 0, 1, 5'd3, 0, 1};
        vecs[7]  = '{"wb_other",      5'd3, 5'd0, 5'd0, 1, 0, 0, 1, 5'd7, 0, 0};
        vecs[8]  = '{"clean",         5'd5, 5'd6, 5'd8, 1, 1, 1, 0, 5'd0, 0, 1};
        vecs[9]  = '{"flush_blocks",  5'd5, 5'd6, 5'd8, 1, 1, 1, 0, 5'd0, 1, 0};
        vecs[10] = '{"two_pend_one",  5'd3, 5'd7, 5'd0, 1, 1, 0, 1, 5'd3, 0, 0};

        rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_wr_rd = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;

        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pending",   pending,     32'd0);
        chk("rst_out_pc",    out_pc,      32'd0);
        chk("rst_rs1_val",   out_rs1_val, 32'd0);
        chk("rst_rs2_val",   out_rs2_val, 32'd0);
        chk("rst_rd_wr",     {26'd0, out_rd, out_wr_rd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic read: x5 loaded via a writeback with no pending bit
        wb(5'd5, 32'h1234);
        cyc();
        wb_en = 1'b0;
        chk("wb_no_pend", pending, 32'd0);
        set_ins(32'h100, 5'd5, 5'd0, 5'd0, 1, 1, 0);
        cyc();
        in_valid = 1'b0;
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_rs1",   out_rs1_val, 32'h1234);
        chk("basic_rs2",   out_rs2_val, 32'd0);

        // RAW stall released by a same-cycle writeback with bypass
        set_ins(32'h104, 5'd1, 5'd2, 5'd3, 0, 0, 1);
        cyc();
        set_ins(32'h108, 5'd3, 5'd0, 5'd4, 1, 0, 0);
        #1;
        chk("raw_pend3", pending, 32'h8);
        chk("raw_stall", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("raw_stall2", {31'd0, in_ready}, 32'd0);
        wb(5'd3, 32'hCAFE);
        #1;
        chk("raw_release", {31'd0, in_ready}, 32'd1);
        cyc();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("raw_bypass", out_rs1_val, 32'hCAFE);
        chk("raw_pc",     out_pc,      32'h108);
        chk("raw_clear",  pending,     32'd0);

        // WAW: second writer of x7 waits for the first writeback; bit stays set
        set_ins(32'h10C, 5'd0, 5'd0, 5'd7, 0, 0, 1);
        cyc();
        set_ins(32'h110, 5'd0, 5'd0, 5'd7, 0, 0, 1);
        #1;
        chk("waw_stall", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("waw_stall2", {31'd0, in_ready}, 32'd0);
        wb(5'd7, 32'h77);
        #1;
        chk("waw_release", {31'd0, in_ready}, 32'd1);
        cyc();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("waw_set_wins", pending, 32'h80);
        chk("waw_pc",       out_pc,  32'h110);
        wb(5'd7, 32'h78);
        cyc();
        wb_en = 1'b0;
        chk("waw_final_clr", pending, 32'd0);

        // Backpressure: slot holds, then back-to-back issue
        out_ready = 1'b0;
        set_ins(32'h114, 5'd5, 5'd7, 5'd0, 1, 1, 0);
        cyc();
        set_ins(32'h118, 5'd7, 5'd5, 5'd0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'd0, in_ready},  32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_pc",    out_pc,      32'h114);
            chk("bp_rs1",   out_rs1_val, 32'h1234);
            chk("bp_rs2",   out_rs2_val, 32'h78);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume", {31'd0, in_ready}, 32'd1);
        cyc();
        chk("b2b_pc_f", out_pc, 32'h118);
        set_ins(32'h11C, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #1;
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("b2b_pc_g", out_pc, 32'h11C);

        // rd=0 writer never sets a pending bit; x0 reads never stall
        set_ins(32'h120, 5'd5, 5'd0, 5'd0, 1, 0, 1);
        cyc();
        chk("rd0_no_pend", pending, 32'd0);
        set_ins(32'h124, 5'd0, 5'd0, 5'd0, 1, 1, 1);
        #1;
        chk("rd0_no_stall", {31'd0, in_ready}, 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("rd0_rs1_zero", out_rs1_val, 32'd0);
        chk("rd0_pc",       out_pc,      32'h124);

        // Hazard table against pending = {x3, x7}
        set_ins(32'h200, 5'd0, 5'd0, 5'd3, 0, 0, 1);
        cyc();
        set_ins(32'h204, 5'd0, 5'd0, 5'd7, 0, 0, 1);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("tbl_pending", pending, 32'h88);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2; in_rd = vecs[i].rd;
            in_use_rs1 = vecs[i].u1; in_use_rs2 = vecs[i].u2; in_wr_rd = vecs[i].wr;
            wb_en = vecs[i].wbe; wb_addr = vecs[i].wba; wb_data = 32'h0; flush = vecs[i].fl;
            #1;
            chk(vecs[i].name, {31'd0, in_ready}, {31'd0, vecs[i].exp_ready});
            wb_en = 1'b0; flush = 1'b0;
        end
        chk("tbl_pending_kept", pending, 32'h88);
        cyc();
        wb(5'd3, 32'h33);
        cyc();
        wb(5'd7, 32'h7A);
        cyc();
        wb_en = 1'b0;
        chk("tbl_cleanup", pending, 32'd0);

        // Flush drops a held writer of x9 and blocks issue in the same cycle
        out_ready = 1'b0;
        set_ins(32'h300, 5'd5, 5'd0, 5'd9, 1, 0, 1);
        cyc();
        set_ins(32'h304, 5'd1, 5'd0, 5'd0, 1, 0, 0);
        flush = 1'b1;
        #1;
        chk("fl_pend9",  pending, 32'h200);
        chk("fl_valid",  {31'd0, out_valid}, 32'd1);
        chk("fl_block",  {31'd0, in_ready},  32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_dropped", {31'd0, out_valid}, 32'd0);
        chk("fl_clr9",    pending, 32'd0);
        out_ready = 1'b1;

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        set_ins(32'h400, 5'd5, 5'd0, 5'd10, 1, 0, 1);
        cyc();
        in_valid = 1'b0;
        chk("ar_valid_pre", {31'd0, out_valid}, 32'd1);
        chk("ar_pend_pre",  pending, 32'h400);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_pend",  pending,     32'd0);
        chk("ar_pc",    out_pc,      32'd0);
        chk("ar_ops",   out_rs1_val | out_rs2_val, 32'd0);
        chk("ar_rd_wr", {26'd0, out_rd, out_wr_rd}, 32'd0);
        q.delete();
        cyc();
        rst = 1'b1; out_ready = 1'b1;
        set_ins(32'h500, 5'd5, 5'd0, 5'd0, 1, 0, 0);
        cyc();
        in_valid = 1'b0;
        chk("post_rst_rs1", out_rs1_val, 32'h1234);
        cyc();
        chk("sb_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
